// File: rtl/user_switch_debouncer.sv
// user_switch_debouncer
// Conditions raw board switch pins for the processor's DIP/push inputs.
// Each channel has a 2-flop synchroniser, then a debounce qualified by a shared 1 ms tick.
// Outputs are clean levels and 1-cycle rise/fall/changed strobes.
// Optional feature: define USER_SW_LONG_PRESS_EN to add per-channel long-press strobes (oSwLong).
// With the macro undefined, oSwLong is tied to 0.
module user_switch_debouncer #(
  parameter int unsigned       pSysClk      = 50000000,
  parameter int unsigned       pWidth       = 8,
  parameter int unsigned       pDebounceMs  = 10,
  parameter logic [pWidth-1:0] pResetLevel  = '0,
  parameter int unsigned       pLongPressMs = 1000
) (
  input  logic              iSysClk,
  input  logic              iSysRst,
  input  logic [pWidth-1:0] iSwRaw,
  output logic [pWidth-1:0] oSwLevel,
  output logic [pWidth-1:0] oSwRise,
  output logic [pWidth-1:0] oSwFall,
  output logic              oSwChanged,
  output logic [pWidth-1:0] oSwLong
);

  localparam int unsigned      cTickDiv = pSysClk / 1000;
  localparam int unsigned      cPreW    = (cTickDiv > 1) ? $clog2(cTickDiv) : 1;
  localparam logic [cPreW-1:0] cPreLast = cPreW'(cTickDiv - 1);
  localparam logic [7:0]       cDebLast = 8'(pDebounceMs - 1);

  logic [cPreW-1:0]       preCntQ;
  logic                   tick;
  logic [pWidth-1:0]      syncMetaQ;
  logic [pWidth-1:0]      syncQ;
  logic [pWidth-1:0]      stableQ;
  logic [pWidth-1:0]      stableD;
  logic [pWidth-1:0][7:0] cntQ;
  logic [pWidth-1:0][7:0] cntD;
  logic [pWidth-1:0]      riseQ;
  logic [pWidth-1:0]      fallQ;
  logic                   changedQ;

  // Tick is asserted in the last cycle of each prescaler period, so it lands on the wrap edge.
  assign tick = (preCntQ == cPreLast);

  // Shared ms prescaler
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      preCntQ <= '0;
    end else if (tick) begin
      preCntQ <= '0;
    end else begin
      preCntQ <= preCntQ + cPreW'(1);
    end
  end

  // Two-flop synchroniser per channel; loads the reset level so release is quiet
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      syncMetaQ <= pResetLevel;
      syncQ     <= pResetLevel;
    end else begin
      syncMetaQ <= iSwRaw;
      syncQ     <= syncMetaQ;
    end
  end

  // Debounce next state: any return to the stable level restarts the qualification count
  always_comb begin
    stableD = stableQ;
    cntD    = cntQ;
    for (int i = 0; i < pWidth; i++) begin
      if (syncQ[i] == stableQ[i]) begin
        cntD[i] = '0;
      end else if (tick) begin
        if (cntQ[i] == cDebLast) begin
          stableD[i] = syncQ[i];
          cntD[i]    = '0;
        end else begin
          cntD[i] = cntQ[i] + 8'd1;
        end
      end
    end
  end

  // Debounce state and registered edge strobes aligned with the level change
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      stableQ  <= pResetLevel;
      cntQ     <= '0;
      riseQ    <= '0;
      fallQ    <= '0;
      changedQ <= 1'b0;
    end else begin
      stableQ  <= stableD;
      cntQ     <= cntD;
      riseQ    <= stableD & ~stableQ;
      fallQ    <= ~stableD & stableQ;
      changedQ <= |(stableD ^ stableQ);
    end
  end

  assign oSwLevel   = stableQ;
  assign oSwRise    = riseQ;
  assign oSwFall    = fallQ;
  assign oSwChanged = changedQ;

`ifdef USER_SW_LONG_PRESS_EN
  localparam logic [15:0] cLongMs = 16'(pLongPressMs);

  logic [pWidth-1:0][15:0] hcntQ;
  logic [pWidth-1:0][15:0] hcntD;
  logic [pWidth-1:0]       longD;
  logic [pWidth-1:0]       longQ;

  // Hold counter saturates at the threshold, so the strobe fires once per press
  always_comb begin
    hcntD = hcntQ;
    longD = '0;
    for (int i = 0; i < pWidth; i++) begin
      if (!stableQ[i]) begin
        hcntD[i] = '0;
      end else if (tick && (hcntQ[i] < cLongMs)) begin
        hcntD[i] = hcntQ[i] + 16'd1;
        longD[i] = (hcntQ[i] == cLongMs - 16'd1);
      end
    end
  end

  // Hold counters and registered long-press strobe
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      hcntQ <= '0;
      longQ <= '0;
    end else begin
      hcntQ <= hcntD;
      longQ <= longD;
    end
  end

  assign oSwLong = longQ;
`else
  assign oSwLong = '0;
`endif

endmodule

// File: tb/tb_user_switch_debouncer.sv
// Scoreboard bench for user_switch_debouncer.
// A tick-level reference model pushes the expected outputs each cycle.
// A monitor pops and compares them; directed tasks add checks on latency windows and strobe counts.
module tb_user_switch_debouncer;

  localparam int unsigned cSysClk = 10000;
  localparam int unsigned cT      = cSysClk / 1000;
  localparam int unsigned cDeb    = 4;
  localparam int unsigned cLong   = 6;
  localparam logic [7:0]  cRst    = 8'h00;

  typedef struct packed {
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
    logic [7:0] lng;
  } obs_t;

  logic       iSysClk = 1'b0;
  logic       iSysRst = 1'b0;
  logic [7:0] iSwRaw  = 8'h00;
  logic [7:0] oSwLevel;
  logic [7:0] oSwRise;
  logic [7:0] oSwFall;
  logic       oSwChanged;
  logic [7:0] oSwLong;

  int nCmp = 0;
  int nBad = 0;

  obs_t expQ[$];

  // Reference model state
  logic [7:0] mMeta;
  logic [7:0] mSync;
  logic [7:0] mStable;
  int         mTicks[8];
  int         mHold[8];
  int         mCyc;

  user_switch_debouncer #(
    .pSysClk      (cSysClk),
    .pWidth       (8),
    .pDebounceMs  (cDeb),
    .pResetLevel  (cRst),
    .pLongPressMs (cLong)
  ) dut (
    .iSysClk    (iSysClk),
    .iSysRst    (iSysRst),
    .iSwRaw     (iSwRaw),
    .oSwLevel   (oSwLevel),
    .oSwRise    (oSwRise),
    .oSwFall    (oSwFall),
    .oSwChanged (oSwChanged),
    .oSwLong    (oSwLong)
  );

  always #5 iSysClk = ~iSysClk;

  task automatic modelReset();
    mMeta   = cRst;
    mSync   = cRst;
    mStable = cRst;
    mCyc    = 0;
    for (int i = 0; i < 8; i++) begin
      mTicks[i] = 0;
      mHold[i]  = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    nCmp++;
    if (got !== req) begin
      nBad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic checkRange(input string name, input int got, input int lo, input int hi);
    nCmp++;
    if (got < lo || got > hi) begin
      nBad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Model: asynchronous reset clears everything immediately
  initial begin : modelRst
    forever begin
      @(negedge iSysRst);
      modelReset();
    end
  end

  // Model: one step per clock edge, push the expected post-edge outputs
  initial begin : modelStep
    obs_t       e;
    logic [7:0] old;
    logic       tickNow;
    modelReset();
    forever begin
      @(posedge iSysClk);
      e = '0;
      if (!iSysRst) begin
        modelReset();
        e.level = cRst;
      end else begin
        // Millisecond ticks fall on every cT-th edge counted from reset release
        tickNow = ((mCyc % cT) == cT - 1);
        mCyc++;
        old = mStable;
        for (int i = 0; i < 8; i++) begin
          if (mSync[i] == mStable[i]) begin
            mTicks[i] = 0;
          end else if (tickNow) begin
            mTicks[i]++;
            if (mTicks[i] == cDeb) begin
              mStable[i] = mSync[i];
              mTicks[i]  = 0;
            end
          end
`ifdef USER_SW_LONG_PRESS_EN
          if (!old[i]) begin
            mHold[i] = 0;
          end else if (tickNow && mHold[i] < cLong) begin
            mHold[i]++;
            if (mHold[i] == cLong) e.lng[i] = 1'b1;
          end
`endif
        end
        mSync   = mMeta;
        mMeta   = iSwRaw;
        e.level = mStable;
        e.rise  = mStable & ~old;
        e.fall  = ~mStable & old;
        e.changed = |(mStable ^ old);
      end
      expQ.push_back(e);
    end
  end

  // Monitor: compare every presented cycle against the scoreboard
  initial begin : monitor
    obs_t e;
    obs_t got;
    forever begin
      @(posedge iSysClk);
      #1;
      got = '{level: oSwLevel, rise: oSwRise, fall: oSwFall, changed: oSwChanged, lng: oSwLong};
      nCmp++;
      if (expQ.size() == 0) begin
        nBad++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = expQ.pop_front();
        if (got !== e) begin
          nBad++;
          $display("FAIL sb at %0t: got lvl=%h r=%h f=%h c=%b l=%h required lvl=%h r=%h f=%h c=%b l=%h",
                   $time, got.level, got.rise, got.fall, got.changed, got.lng,
                   e.level, e.rise, e.fall, e.changed, e.lng);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic settle(input logic [7:0] val);
    @(negedge iSysClk);
    iSwRaw = val;
    repeat (60) @(posedge iSysClk);
  endtask

  initial begin : stim
    int   n;
    int   cnt;
    bit   found;
    logic [7:0] riseAt;
    logic       chAt;

    // 1. Reset held with all pins high
    iSysRst = 1'b0;
    iSwRaw  = 8'hFF;
    repeat (20) @(posedge iSysClk);
    #1;
    check("rst_level", oSwLevel, 8'h00);
    check("rst_strobes", {oSwRise, oSwFall, oSwChanged, oSwLong}, 0);
    @(negedge iSysClk);
    iSwRaw  = 8'h00;
    iSysRst = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(posedge iSysClk);
      #1;
      if ((|oSwRise) || (|oSwFall) || oSwChanged) cnt++;
    end
    check("no_strobe_after_release", cnt, 0);

    // 2. Single channel step
    @(negedge iSysClk);
    iSwRaw[0] = 1'b1;
    found = 0;
    n = 0;
    riseAt = '0;
    chAt = 1'b0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge iSysClk);
      #1;
      if (oSwLevel[0]) begin
        found  = 1;
        n      = k;
        riseAt = oSwRise;
        chAt   = oSwChanged;
      end
    end
    checkRange("t2_latency", n, 33, 42);
    check("t2_rise", riseAt, 8'h01);
    check("t2_changed", chAt, 1'b1);
    @(posedge iSysClk);
    #1;
    check("t2_rise_one_cycle", {oSwRise, oSwChanged}, 0);

    // 3. Toggling faster than the debounce window
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge iSysClk);
      iSwRaw[1] = ~iSwRaw[1];
      repeat (15) begin
        @(posedge iSysClk);
        #1;
        if (oSwLevel[1] || oSwRise[1] || oSwFall[1]) cnt++;
      end
    end
    check("t3_bounce_ignored", cnt, 0);

    // 4. Simultaneous multi-channel step
    settle(8'h00);
    @(negedge iSysClk);
    iSwRaw = 8'hF0;
    found = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge iSysClk);
      #1;
      if (oSwLevel != 8'h00) begin
        found = 1;
        check("t4_level", oSwLevel, 8'hF0);
        check("t4_rise", oSwRise, 8'hF0);
        check("t4_changed", oSwChanged, 1'b1);
      end
    end
    check("t4_found", found, 1'b1);
    cnt = 0;
    repeat (60) begin
      @(posedge iSysClk);
      #1;
      if (oSwChanged) cnt++;
    end
    check("t4_changed_once", cnt, 0);

    // 5. Reset in the middle of a qualification
    settle(8'h00);
    @(negedge iSysClk);
    iSwRaw[2] = 1'b1;
    repeat (38) @(negedge iSysClk);
    iSysRst = 1'b0;
    repeat (3) @(negedge iSysClk);
    check("t5_level_in_reset", oSwLevel, 8'h00);
    iSysRst = 1'b1;
    found = 0;
    n = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge iSysClk);
      #1;
      if (oSwLevel[2]) begin
        found = 1;
        n     = k;
      end
    end
    checkRange("t5_latency_from_release", n, 33, 42);

    // 6. Long press on channel 3
    settle(8'h00);
    @(negedge iSysClk);
    iSwRaw[3] = 1'b1;
    found = 0;
    cnt = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      @(posedge iSysClk);
      #1;
      if (oSwLong != 8'h00) cnt++;
      if (oSwRise[3]) found = 1;
    end
    check("t6_rise_seen", found, 1'b1);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge iSysClk);
      #1;
      if (oSwLong != 8'h00) begin
        cnt++;
        if (n == 0) n = k;
`ifdef USER_SW_LONG_PRESS_EN
        check("t6_long_bits", oSwLong, 8'h08);
`endif
      end
    end
`ifdef USER_SW_LONG_PRESS_EN
    check("t6_long_once", cnt, 1);
    checkRange("t6_long_delay", n, 55, 65);
`else
    check("t6_long_tied_off", cnt, 0);
`endif

    // Randomised soak, one mid-run reset; the scoreboard does the checking
    for (int r = 0; r < 60; r++) begin
      @(negedge iSysClk);
      if (r == 30) begin
        iSysRst = 1'b0;
        repeat (2) @(negedge iSysClk);
        iSysRst = 1'b1;
      end
      iSwRaw = iSwRaw ^ 8'($urandom);
      repeat ($urandom_range(3, 50)) @(negedge iSysClk);
    end

    repeat (5) @(posedge iSysClk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
